// File: rtl/tlb_array_if.sv
// Bus bundle for tlb_array: two search ports, write/read ports, INVTLB strobe and fill index.
interface tlb_array_if #(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned IDXW   = $clog2(TLBNUM)
);
    logic            s0_req, s0_odd_page, s0_valid, s0_found, s0_multi, s0_v, s0_d;
    logic [18:0]     s0_vppn;
    logic [9:0]      s0_asid;
    logic [IDXW-1:0] s0_index;
    logic [5:0]      s0_ps;
    logic [19:0]     s0_ppn;
    logic [1:0]      s0_mat, s0_plv;

    logic            s1_req, s1_odd_page, s1_valid, s1_found, s1_multi, s1_v, s1_d;
    logic [18:0]     s1_vppn;
    logic [9:0]      s1_asid;
    logic [IDXW-1:0] s1_index;
    logic [5:0]      s1_ps;
    logic [19:0]     s1_ppn;
    logic [1:0]      s1_mat, s1_plv;

    logic            we, w_g, w_e, w_v0, w_d0, w_v1, w_d1;
    logic [IDXW-1:0] w_index;
    logic [18:0]     w_vppn;
    logic [9:0]      w_asid;
    logic [5:0]      w_ps;
    logic [1:0]      w_mat0, w_plv0, w_mat1, w_plv1;
    logic [19:0]     w_ppn0, w_ppn1;

    logic [IDXW-1:0] r_index;
    logic            r_g, r_e, r_v0, r_d0, r_v1, r_d1;
    logic [18:0]     r_vppn;
    logic [9:0]      r_asid;
    logic [5:0]      r_ps;
    logic [1:0]      r_mat0, r_plv0, r_mat1, r_plv1;
    logic [19:0]     r_ppn0, r_ppn1;

    logic            inv_en, inv_err;
    logic [4:0]      inv_op;
    logic [9:0]      inv_asid;
    logic [18:0]     inv_vpn;
    logic [IDXW-1:0] fill_index;

    modport master (
        output s0_req, s0_vppn, s0_odd_page, s0_asid,
        output s1_req, s1_vppn, s1_odd_page, s1_asid,
        output we, w_index, w_vppn, w_asid, w_g, w_ps, w_e,
        output w_v0, w_d0, w_mat0, w_plv0, w_ppn0, w_v1, w_d1, w_mat1, w_plv1, w_ppn1,
        output r_index, inv_en, inv_op, inv_asid, inv_vpn,
        input  s0_valid, s0_found, s0_multi, s0_index, s0_ps, s0_ppn, s0_v, s0_d, s0_mat, s0_plv,
        input  s1_valid, s1_found, s1_multi, s1_index, s1_ps, s1_ppn, s1_v, s1_d, s1_mat, s1_plv,
        input  r_vppn, r_asid, r_g, r_ps, r_e,
        input  r_v0, r_d0, r_mat0, r_plv0, r_ppn0, r_v1, r_d1, r_mat1, r_plv1, r_ppn1,
        input  inv_err, fill_index
    );

    modport slave (
        input  s0_req, s0_vppn, s0_odd_page, s0_asid,
        input  s1_req, s1_vppn, s1_odd_page, s1_asid,
        input  we, w_index, w_vppn, w_asid, w_g, w_ps, w_e,
        input  w_v0, w_d0, w_mat0, w_plv0, w_ppn0, w_v1, w_d1, w_mat1, w_plv1, w_ppn1,
        input  r_index, inv_en, inv_op, inv_asid, inv_vpn,
        output s0_valid, s0_found, s0_multi, s0_index, s0_ps, s0_ppn, s0_v, s0_d, s0_mat, s0_plv,
        output s1_valid, s1_found, s1_multi, s1_index, s1_ps, s1_ppn, s1_v, s1_d, s1_mat, s1_plv,
        output r_vppn, r_asid, r_g, r_ps, r_e,
        output r_v0, r_d0, r_mat0, r_plv0, r_ppn0, r_v1, r_d1, r_mat1, r_plv1, r_ppn1,
        output inv_err, fill_index
    );
endinterface

// File: rtl/tlb_array.sv
// Fully associative LoongArch TLB store: registered dual search with multi-hit flag,
// INVTLB, combinational read and LFSR-backed TLBFILL victim selection.
module tlb_array #(
    parameter int unsigned TLBNUM    = 16,
    parameter int unsigned IDXW      = $clog2(TLBNUM),
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic        clk,
    input logic        resetn,
    tlb_array_if.slave bus
);
    typedef struct packed {
        logic        v;
        logic        d;
        logic [1:0]  mat;
        logic [1:0]  plv;
        logic [19:0] ppn;
    } page_t;

    typedef struct packed {
        logic            found;
        logic            multi;
        logic [IDXW-1:0] index;
        logic [5:0]      ps;
        page_t           pg;
    } res_t;

    logic [18:0]     r_vppn [TLBNUM];
    logic [9:0]      r_asid [TLBNUM];
    logic [5:0]      r_ps   [TLBNUM];
    page_t           r_pg   [TLBNUM][2];
    logic [TLBNUM-1:0] r_g;
    logic [TLBNUM-1:0] r_e;

    res_t            r_s0, r_s1;
    logic            r_s0_vld, r_s1_vld;
    logic            r_inv_err;
    logic [15:0]     r_lfsr;

    res_t            w_res0, w_res1;
    logic [TLBNUM-1:0] w_inv_clr;
    logic [IDXW-1:0] w_fill;
    logic            w_any_free;

    function automatic logic va_match(input logic [5:0] ps, input logic [18:0] a,
                                      input logic [18:0] b);
        if (ps == 6'd12) return a == b;
        if (ps == 6'd21) return a[18:9] == b[18:9];
        return 1'b0;
    endfunction

    // Ascending scan: the first hit is kept, any later hit only raises multi.
    function automatic res_t tlb_search(input logic [18:0] vppn, input logic odd,
                                        input logic [9:0] asid);
        res_t res;
        logic sel;
        res = '0;
        sel = 1'b0;
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            if (r_e[i] && (r_g[i] || r_asid[i] == asid) && va_match(r_ps[i], r_vppn[i], vppn)) begin
                if (res.found) begin
                    res.multi = 1'b1;
                end else begin
                    sel       = (r_ps[i] == 6'd12) ? odd : vppn[8];
                    res.found = 1'b1;
                    res.index = IDXW'(i);
                    res.ps    = r_ps[i];
                    res.pg    = r_pg[i][sel];
                end
            end
        end
        return res;
    endfunction

    always_comb w_res0 = tlb_search(bus.s0_vppn, bus.s0_odd_page, bus.s0_asid);
    always_comb w_res1 = tlb_search(bus.s1_vppn, bus.s1_odd_page, bus.s1_asid);

    always_comb begin
        w_inv_clr = '0;
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            case (bus.inv_op)
                5'd0, 5'd1: w_inv_clr[i] = 1'b1;
                5'd2:       w_inv_clr[i] = r_g[i];
                5'd3:       w_inv_clr[i] = !r_g[i];
                5'd4:       w_inv_clr[i] = !r_g[i] && (r_asid[i] == bus.inv_asid);
                5'd5:       w_inv_clr[i] = !r_g[i] && (r_asid[i] == bus.inv_asid)
                                           && va_match(r_ps[i], r_vppn[i], bus.inv_vpn);
                5'd6:       w_inv_clr[i] = (r_g[i] || (r_asid[i] == bus.inv_asid))
                                           && va_match(r_ps[i], r_vppn[i], bus.inv_vpn);
                default:    w_inv_clr[i] = 1'b0;
            endcase
        end
    end

    // A write to an entry overrides an invalidation of that same entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_e <= '0;
        end else begin
            for (int unsigned i = 0; i < TLBNUM; i++) begin
                if (bus.we && bus.w_index == IDXW'(i)) r_e[i] <= bus.w_e;
                else if (bus.inv_en && w_inv_clr[i])   r_e[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.we) begin
            r_vppn[bus.w_index]  <= bus.w_vppn;
            r_asid[bus.w_index]  <= bus.w_asid;
            r_g[bus.w_index]     <= bus.w_g;
            r_ps[bus.w_index]    <= bus.w_ps;
            r_pg[bus.w_index][0] <= '{v: bus.w_v0, d: bus.w_d0, mat: bus.w_mat0,
                                      plv: bus.w_plv0, ppn: bus.w_ppn0};
            r_pg[bus.w_index][1] <= '{v: bus.w_v1, d: bus.w_d1, mat: bus.w_mat1,
                                      plv: bus.w_plv1, ppn: bus.w_ppn1};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s0_vld  <= 1'b0;
            r_s1_vld  <= 1'b0;
            r_s0      <= '0;
            r_s1      <= '0;
            r_inv_err <= 1'b0;
            r_lfsr    <= LFSR_SEED;
        end else begin
            if (bus.s0_req) begin
                r_s0_vld <= 1'b1;
                r_s0     <= w_res0;
            end
            if (bus.s1_req) begin
                r_s1_vld <= 1'b1;
                r_s1     <= w_res1;
            end
            r_inv_err <= bus.inv_en && (bus.inv_op > 5'd6);
            r_lfsr    <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        end
    end

    always_comb begin
        w_fill     = r_lfsr[IDXW-1:0];
        w_any_free = 1'b0;
        for (int unsigned i = 0; i < TLBNUM; i++) begin
            if (!r_e[i] && !w_any_free) begin
                w_fill     = IDXW'(i);
                w_any_free = 1'b1;
            end
        end
    end

    assign bus.s0_valid = r_s0_vld;
    assign bus.s0_found = r_s0.found;
    assign bus.s0_multi = r_s0.multi;
    assign bus.s0_index = r_s0.index;
    assign bus.s0_ps    = r_s0.ps;
    assign bus.s0_ppn   = r_s0.pg.ppn;
    assign bus.s0_v     = r_s0.pg.v;
    assign bus.s0_d     = r_s0.pg.d;
    assign bus.s0_mat   = r_s0.pg.mat;
    assign bus.s0_plv   = r_s0.pg.plv;

    assign bus.s1_valid = r_s1_vld;
    assign bus.s1_found = r_s1.found;
    assign bus.s1_multi = r_s1.multi;
    assign bus.s1_index = r_s1.index;
    assign bus.s1_ps    = r_s1.ps;
    assign bus.s1_ppn   = r_s1.pg.ppn;
    assign bus.s1_v     = r_s1.pg.v;
    assign bus.s1_d     = r_s1.pg.d;
    assign bus.s1_mat   = r_s1.pg.mat;
    assign bus.s1_plv   = r_s1.pg.plv;

    assign bus.r_vppn = r_vppn[bus.r_index];
    assign bus.r_asid = r_asid[bus.r_index];
    assign bus.r_g    = r_g[bus.r_index];
    assign bus.r_ps   = r_ps[bus.r_index];
    assign bus.r_e    = r_e[bus.r_index];
    assign bus.r_v0   = r_pg[bus.r_index][0].v;
    assign bus.r_d0   = r_pg[bus.r_index][0].d;
    assign bus.r_mat0 = r_pg[bus.r_index][0].mat;
    assign bus.r_plv0 = r_pg[bus.r_index][0].plv;
    assign bus.r_ppn0 = r_pg[bus.r_index][0].ppn;
    assign bus.r_v1   = r_pg[bus.r_index][1].v;
    assign bus.r_d1   = r_pg[bus.r_index][1].d;
    assign bus.r_mat1 = r_pg[bus.r_index][1].mat;
    assign bus.r_plv1 = r_pg[bus.r_index][1].plv;
    assign bus.r_ppn1 = r_pg[bus.r_index][1].ppn;

    assign bus.inv_err    = r_inv_err;
    assign bus.fill_index = w_fill;
endmodule

// File: tb/tb_tlb_array.sv
// Bench for tlb_array: reference TLB model checked every cycle, plus directed literal checks.
module tb_tlb_array;
    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;

    typedef struct packed {
        logic e; logic [18:0] vppn; logic [9:0] asid; logic g; logic [5:0] ps;
        logic [1:0] v; logic [1:0] d; logic [1:0][1:0] mat; logic [1:0][1:0] plv;
        logic [1:0][19:0] ppn;
    } ent_t;

    typedef struct packed {
        logic valid; logic found; logic multi; logic [IDXW-1:0] index; logic [5:0] ps;
        logic [19:0] ppn; logic v; logic d; logic [1:0] mat; logic [1:0] plv;
    } sres_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    tlb_array_if #(.TLBNUM(TLBNUM)) bus ();
    tlb_array #(.TLBNUM(TLBNUM), .LFSR_SEED(16'hACE1)) u_dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t        m_tlb [TLBNUM];
    bit          m_written [TLBNUM];
    sres_t       m_s [2];
    logic        m_inv_err;
    logic [15:0] m_lfsr;
    sres_t       m_n0, m_n1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] fb;
        fb = (x ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'd1;
        return (x >> 1) | (fb << 15);
    endfunction

    function automatic bit va_eq(input logic [5:0] ps, input logic [18:0] a, input logic [18:0] b);
        if (ps == 12) return a == b;
        if (ps == 21) return (a >> 9) == (b >> 9);
        return 0;
    endfunction

    function automatic sres_t model_search(input logic [18:0] vppn, input logic odd,
                                           input logic [9:0] asid);
        int    hits[$];
        sres_t r;
        ent_t  t;
        int    sel;
        r = '0;
        r.valid = 1'b1;
        for (int i = 0; i < TLBNUM; i++) begin
            t = m_tlb[i];
            if (t.e && (t.g || t.asid == asid) && va_eq(t.ps, t.vppn, vppn)) hits.push_back(i);
        end
        if (hits.size() > 0) begin
            t = m_tlb[hits[0]];
            sel = (t.ps == 12) ? int'(odd) : int'(vppn[8]);
            r.found = 1'b1;
            r.multi = hits.size() > 1;
            r.index = IDXW'(hits[0]);
            r.ps    = t.ps;
            r.ppn   = t.ppn[sel];
            r.v     = t.v[sel];
            r.d     = t.d[sel];
            r.mat   = t.mat[sel];
            r.plv   = t.plv[sel];
        end
        return r;
    endfunction

    function automatic bit inv_hits(input ent_t t, input int op, input logic [9:0] asid,
                                    input logic [18:0] vpn);
        bit am, va;
        am = t.asid == asid;
        va = va_eq(t.ps, t.vppn, vpn);
        case (op)
            0, 1:    return 1;
            2:       return t.g;
            3:       return !t.g;
            4:       return !t.g && am;
            5:       return !t.g && am && va;
            6:       return (t.g || am) && va;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) m_tlb[i].e = 1'b0;
            m_s[0] = '0;
            m_s[1] = '0;
            m_inv_err = 1'b0;
            m_lfsr = 16'hACE1;
        end else begin
            m_n0 = bus.s0_req ? model_search(bus.s0_vppn, bus.s0_odd_page, bus.s0_asid) : m_s[0];
            m_n1 = bus.s1_req ? model_search(bus.s1_vppn, bus.s1_odd_page, bus.s1_asid) : m_s[1];
            if (bus.inv_en)
                for (int i = 0; i < TLBNUM; i++)
                    if (inv_hits(m_tlb[i], int'(bus.inv_op), bus.inv_asid, bus.inv_vpn))
                        m_tlb[i].e = 1'b0;
            if (bus.we) begin
                m_tlb[bus.w_index].e      = bus.w_e;
                m_tlb[bus.w_index].vppn   = bus.w_vppn;
                m_tlb[bus.w_index].asid   = bus.w_asid;
                m_tlb[bus.w_index].g      = bus.w_g;
                m_tlb[bus.w_index].ps     = bus.w_ps;
                m_tlb[bus.w_index].v      = {bus.w_v1, bus.w_v0};
                m_tlb[bus.w_index].d      = {bus.w_d1, bus.w_d0};
                m_tlb[bus.w_index].mat    = {bus.w_mat1, bus.w_mat0};
                m_tlb[bus.w_index].plv    = {bus.w_plv1, bus.w_plv0};
                m_tlb[bus.w_index].ppn    = {bus.w_ppn1, bus.w_ppn0};
                m_written[bus.w_index]    = 1'b1;
            end
            m_s[0] = m_n0;
            m_s[1] = m_n1;
            m_inv_err = bus.inv_en && (bus.inv_op > 6);
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        sres_t a0, a1;
        int    ef;
        ent_t  t;
        if (resetn) begin
            a0 = '{valid: bus.s0_valid, found: bus.s0_found, multi: bus.s0_multi,
                   index: bus.s0_index, ps: bus.s0_ps, ppn: bus.s0_ppn, v: bus.s0_v,
                   d: bus.s0_d, mat: bus.s0_mat, plv: bus.s0_plv};
            a1 = '{valid: bus.s1_valid, found: bus.s1_found, multi: bus.s1_multi,
                   index: bus.s1_index, ps: bus.s1_ps, ppn: bus.s1_ppn, v: bus.s1_v,
                   d: bus.s1_d, mat: bus.s1_mat, plv: bus.s1_plv};
            chk("s0_result", 64'(a0), 64'(m_s[0]));
            chk("s1_result", 64'(a1), 64'(m_s[1]));
            chk("inv_err", 64'(bus.inv_err), 64'(m_inv_err));
            ef = -1;
            for (int i = TLBNUM - 1; i >= 0; i--) if (!m_tlb[i].e) ef = i;
            if (ef < 0) ef = int'(m_lfsr % TLBNUM);
            chk("fill_index", 64'(bus.fill_index), 64'(ef));
            t = m_tlb[bus.r_index];
            chk("r_e", 64'(bus.r_e), 64'(t.e));
            if (m_written[bus.r_index]) begin
                chk("r_tag", {bus.r_vppn, bus.r_asid, bus.r_g, bus.r_ps},
                    {t.vppn, t.asid, t.g, t.ps});
                chk("r_page0", {bus.r_v0, bus.r_d0, bus.r_mat0, bus.r_plv0, bus.r_ppn0},
                    {t.v[0], t.d[0], t.mat[0], t.plv[0], t.ppn[0]});
                chk("r_page1", {bus.r_v1, bus.r_d1, bus.r_mat1, bus.r_plv1, bus.r_ppn1},
                    {t.v[1], t.d[1], t.mat[1], t.plv[1], t.ppn[1]});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.s0_req = 0; bus.s1_req = 0; bus.we = 0; bus.inv_en = 0;
    endtask

    task automatic set_wr(input int idx, input logic [18:0] vppn, input logic [9:0] asid,
                          input logic g, input logic [5:0] ps, input logic [19:0] p0,
                          input logic [19:0] p1);
        bus.we = 1; bus.w_index = IDXW'(idx); bus.w_vppn = vppn; bus.w_asid = asid;
        bus.w_g = g; bus.w_ps = ps; bus.w_e = 1;
        bus.w_v0 = 1; bus.w_d0 = 1; bus.w_mat0 = 2'd1; bus.w_plv0 = 2'd3; bus.w_ppn0 = p0;
        bus.w_v1 = 1; bus.w_d1 = 0; bus.w_mat1 = 2'd2; bus.w_plv1 = 2'd0; bus.w_ppn1 = p1;
    endtask

    task automatic wr(input int idx, input logic [18:0] vppn, input logic [9:0] asid,
                      input logic g, input logic [5:0] ps, input logic [19:0] p0,
                      input logic [19:0] p1);
        set_wr(idx, vppn, asid, g, ps, p0, p1);
        tick();
        idle();
    endtask

    task automatic set_s0(input logic [18:0] vppn, input logic odd, input logic [9:0] asid);
        bus.s0_req = 1; bus.s0_vppn = vppn; bus.s0_odd_page = odd; bus.s0_asid = asid;
    endtask

    task automatic srch0(input logic [18:0] vppn, input logic odd, input logic [9:0] asid);
        set_s0(vppn, odd, asid);
        tick();
        idle();
    endtask

    task automatic inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vpn);
        bus.inv_en = 1; bus.inv_op = op; bus.inv_asid = asid; bus.inv_vpn = vpn;
        tick();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        bus.s0_vppn = '0; bus.s0_odd_page = 0; bus.s0_asid = '0;
        bus.s1_vppn = '0; bus.s1_odd_page = 0; bus.s1_asid = '0;
        bus.r_index = '0; bus.inv_op = '0; bus.inv_asid = '0; bus.inv_vpn = '0;
        set_wr(0, '0, '0, 0, 6'd12, '0, '0);
        bus.we = 0;

        chk("lfsr_pin1", 64'(lfsr_step(16'hACE1)), 64'h5670);
        chk("lfsr_pin2", 64'(lfsr_step(lfsr_step(16'hACE1))), 64'hAB38);

        repeat (3) tick();
        chk("rst_s0_valid", 64'(bus.s0_valid), 64'd0);
        chk("rst_fill", 64'(bus.fill_index), 64'd0);
        resetn = 1;
        tick();

        srch0(19'h00042, 0, 10'd1);
        chk("miss_valid", 64'(bus.s0_valid), 64'd1);
        chk("miss_found", 64'(bus.s0_found), 64'd0);
        chk("miss_index", 64'(bus.s0_index), 64'd0);
        chk("miss_fill", 64'(bus.fill_index), 64'd0);

        wr(3, 19'h01234, 10'd5, 0, 6'd12, 20'h00003, 20'hABCDE);
        srch0(19'h01234, 1, 10'd5);
        chk("hit3_found", 64'(bus.s0_found), 64'd1);
        chk("hit3_index", 64'(bus.s0_index), 64'd3);
        chk("hit3_ppn", 64'(bus.s0_ppn), 64'hABCDE);
        chk("hit3_v", 64'(bus.s0_v), 64'd1);
        srch0(19'h01234, 1, 10'd6);
        chk("asid_miss", 64'(bus.s0_found), 64'd0);

        wr(2, 19'h7FE00, 10'd0, 1, 6'd21, 20'h11111, 20'h22222);
        bus.s1_req = 1; bus.s1_vppn = 19'h7FE37; bus.s1_odd_page = 1; bus.s1_asid = 10'd9;
        tick();
        idle();
        chk("big_found", 64'(bus.s1_found), 64'd1);
        chk("big_index", 64'(bus.s1_index), 64'd2);
        chk("big_ppn", 64'(bus.s1_ppn), 64'h11111);
        chk("big_ps", 64'(bus.s1_ps), 64'd21);

        wr(1, 19'h01234, 10'd5, 0, 6'd12, 20'h00001, 20'h33333);
        wr(5, 19'h01234, 10'd5, 0, 6'd12, 20'h00005, 20'h55555);
        set_s0(19'h01234, 1, 10'd5);
        set_wr(1, 19'h0AAAA, 10'd5, 0, 6'd12, 20'h00001, 20'h44444);
        tick();
        idle();
        chk("multi_index", 64'(bus.s0_index), 64'd1);
        chk("multi_flag", 64'(bus.s0_multi), 64'd1);
        chk("multi_ppn", 64'(bus.s0_ppn), 64'h33333);
        tick();
        chk("hold_index", 64'(bus.s0_index), 64'd1);
        chk("hold_valid", 64'(bus.s0_valid), 64'd1);
        srch0(19'h01234, 1, 10'd5);
        chk("multi2_index", 64'(bus.s0_index), 64'd3);
        chk("multi2_flag", 64'(bus.s0_multi), 64'd1);

        wr(4, 19'h01234, 10'd7, 1, 6'd12, 20'h00004, 20'h66666);
        inv(5'd5, 10'd5, 19'h01234);
        bus.r_index = 4'd3; #1;
        chk("op5_e3", 64'(bus.r_e), 64'd0);
        bus.r_index = 4'd4; #1;
        chk("op5_e4", 64'(bus.r_e), 64'd1);
        chk("op5_fill", 64'(bus.fill_index), 64'd0);
        srch0(19'h01234, 1, 10'd5);
        chk("op5_srch", 64'(bus.s0_index), 64'd4);
        inv(5'd9, 10'd0, 19'h0);
        chk("op9_err", 64'(bus.inv_err), 64'd1);
        chk("op9_e4", 64'(bus.r_e), 64'd1);
        tick();
        chk("op9_err_end", 64'(bus.inv_err), 64'd0);

        bus.inv_en = 1; bus.inv_op = 5'd0;
        set_wr(6, 19'h00666, 10'd6, 0, 6'd12, 20'h00006, 20'h00066);
        tick();
        idle();
        bus.r_index = 4'd6; #1;
        chk("we_inv_e6", 64'(bus.r_e), 64'd1);
        bus.r_index = 4'd4; #1;
        chk("we_inv_e4", 64'(bus.r_e), 64'd0);

        for (int i = 0; i < TLBNUM; i++)
            wr(i, 19'h00100 + 19'(i), 10'(i), i[0], (i == 15) ? 6'd13 : 6'd12,
               20'(i), 20'(i << 4));
        for (int i = 0; i < 20; i++) begin
            bus.r_index = IDXW'(i);
            tick();
        end
        srch0(19'h0010F, 0, 10'd15);
        chk("ps13_miss", 64'(bus.s0_found), 64'd0);
        srch0(19'h00107, 0, 10'd99);
        chk("g_hit_index", 64'(bus.s0_index), 64'd7);
        chk("g_hit_ppn", 64'(bus.s0_ppn), 64'd7);
        inv(5'd2, 10'd0, 19'h0);
        chk("op2_fill", 64'(bus.fill_index), 64'd1);
        inv(5'd4, 10'd0, 19'h0);
        chk("op4_fill", 64'(bus.fill_index), 64'd0);
        inv(5'd6, 10'd2, 19'h00102);
        bus.r_index = 4'd2; #1;
        chk("op6_e2", 64'(bus.r_e), 64'd0);
        bus.r_index = 4'd4; #1;
        chk("op6_e4", 64'(bus.r_e), 64'd1);
        inv(5'd3, 10'd0, 19'h0);
        chk("op3_e4", 64'(bus.r_e), 64'd0);

        wr(0, 19'h00055, 10'd1, 0, 6'd12, 20'h00AAA, 20'h00BBB);
        srch0(19'h00055, 0, 10'd1);
        chk("pre_rst_found", 64'(bus.s0_found), 64'd1);
        set_s0(19'h00055, 0, 10'd1);
        #2;
        resetn = 0;
        #1;
        idle();
        bus.r_index = 4'd0; #1;
        chk("rst_valid", 64'(bus.s0_valid), 64'd0);
        chk("rst_found", 64'(bus.s0_found), 64'd0);
        chk("rst_e0", 64'(bus.r_e), 64'd0);
        chk("rst_fill0", 64'(bus.fill_index), 64'd0);
        repeat (2) tick();
        resetn = 1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
